// File: rtl/rotation_matrix_engine.sv
// rotation_matrix_engine
//   Builds the 3x3 homogeneous rotation matrix M = T(+c) * R(theta) * T(-c)
//   about the centre (cx, cy) with a single sequential multiplier: pass 1
//   forms P = T1*R, pass 2 forms M = P*T2 (27 multiply-accumulates each, i
//   outer / j middle / k inner). The finished M is copied into a result bank
//   that is read through a registered selection port, so readers always see
//   a complete matrix from the previous run.
//
//   Optional feature macro: ROT_MATRIX_SAT_EN
//     defined   : each W-bit reduction clamps to the signed range and sets
//                 the sticky sat_flag
//     undefined : reductions wrap (keep low W bits), sat_flag tied to 0
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset (aborts a run, clears bank)
//   start          begin a run; only sampled in IDLE
//   angle_idx      angle table index, latched with start
//   cx, cy         unsigned integer rotation centre, latched with start
//   busy           high whenever the engine is not idle
//   done           one-cycle pulse while the result bank is being updated
//   selection      element index 0..8 row-major; 9..15 read as 0
//   selected_value registered element read, signed Q(INT_W).(FRAC_W)
//   sat_flag       sticky per run: some reduction clamped
module rotation_matrix_engine #(
  parameter int INT_W          = 13,
  parameter int FRAC_W         = 20,
  parameter int ANGLE_W        = 3,
  parameter int ANGLE_STEP_DEG = 15,
  parameter int COORD_W        = 11,
  localparam int W             = INT_W + FRAC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ANGLE_W-1:0] angle_idx,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic               busy,
  output logic               done,
  input  logic [3:0]         selection,
  output logic [W-1:0]       selected_value,
  output logic               sat_flag
);

  localparam int  N_ANG = 2 ** ANGLE_W;
  localparam real PI    = 3.14159265358979323846;
  localparam logic signed [W-1:0] ONE = W'(1) << FRAC_W;
  // Half an LSB of the shifted product, for round-half-up.
  localparam logic [2*W-1:0] RND = (2*W)'(1) << (FRAC_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PASS1, S_PASS2, S_DONE} state_t;

  state_t state_reg, state_next;

  // cos/sin table, rounded to nearest at elaboration. The +0.5/floor form
  // makes cos(90 deg) (about 6e-17) land exactly on 0.
  logic signed [W-1:0] cos_lut [N_ANG];
  logic signed [W-1:0] sin_lut [N_ANG];

  generate
    for (genvar gi = 0; gi < N_ANG; gi++) begin : g_lut
      localparam real THETA = real'(gi * ANGLE_STEP_DEG) * PI / 180.0;
      localparam longint COS_Q = longint'($floor($cos(THETA) * (2.0 ** FRAC_W) + 0.5));
      localparam longint SIN_Q = longint'($floor($sin(THETA) * (2.0 ** FRAC_W) + 0.5));
      assign cos_lut[gi] = W'(COS_Q);
      assign sin_lut[gi] = W'(SIN_Q);
    end
  endgenerate

  logic [ANGLE_W-1:0]  angle_reg;
  logic [COORD_W-1:0]  cx_reg, cy_reg;
  logic [1:0]          i_reg, j_reg, k_reg;
  logic signed [W+2:0] acc_reg;
  logic signed [W-1:0] p_reg    [9];
  logic signed [W-1:0] m_reg    [9];
  logic signed [W-1:0] bank_reg [9];

  logic signed [W-1:0]   cx_q, cy_q, cos_v, sin_v;
  logic [3:0]            a_idx, b_idx, o_idx;
  logic signed [W-1:0]   t1_e, r_e, t2_e, a_op, b_op;
  logic signed [2*W-1:0] prod;
  logic [2*W-1:0]        rsum;
  logic signed [W+2:0]   term, acc_sum;
  logic signed [W-1:0]   reduced;
  logic                  in_pass, last_mac;
  logic                  unused_rsum;

  // Centre in Q format: integer pixels shifted up by FRAC_W, always positive.
  assign cx_q  = {{(INT_W-COORD_W){1'b0}}, cx_reg, {FRAC_W{1'b0}}};
  assign cy_q  = {{(INT_W-COORD_W){1'b0}}, cy_reg, {FRAC_W{1'b0}}};
  assign cos_v = cos_lut[angle_reg];
  assign sin_v = sin_lut[angle_reg];

  assign in_pass  = (state_reg == S_PASS1) || (state_reg == S_PASS2);
  assign last_mac = (i_reg == 2'd2) && (j_reg == 2'd2) && (k_reg == 2'd2);

  // Operand element indices: A[i][k] and B[k][j]; output element [i][j].
  assign a_idx = {2'b00, i_reg} * 4'd3 + {2'b00, k_reg};
  assign b_idx = {2'b00, k_reg} * 4'd3 + {2'b00, j_reg};
  assign o_idx = {2'b00, i_reg} * 4'd3 + {2'b00, j_reg};

  // Constant-structure matrices are generated on the fly from the latched
  // centre and angle instead of being stored.
  always_comb begin
    t1_e = '0;
    case (a_idx)
      4'd0, 4'd4, 4'd8: t1_e = ONE;
      4'd2:             t1_e = cx_q;
      4'd5:             t1_e = cy_q;
      default:          t1_e = '0;
    endcase
    r_e = '0;
    case (b_idx)
      4'd0, 4'd4: r_e = cos_v;
      4'd1:       r_e = -sin_v;
      4'd3:       r_e = sin_v;
      4'd8:       r_e = ONE;
      default:    r_e = '0;
    endcase
    t2_e = '0;
    case (b_idx)
      4'd0, 4'd4, 4'd8: t2_e = ONE;
      4'd2:             t2_e = -cx_q;
      4'd5:             t2_e = -cy_q;
      default:          t2_e = '0;
    endcase
  end

  assign a_op = (state_reg == S_PASS2) ? p_reg[a_idx] : t1_e;
  assign b_op = (state_reg == S_PASS2) ? t2_e : r_e;

  // One MAC: full product, round half up, drop FRAC_W bits, accumulate.
  assign prod        = (2*W)'(a_op) * (2*W)'(b_op);
  assign rsum        = prod + RND;
  assign term        = rsum[FRAC_W +: W+3];
  assign acc_sum     = ((k_reg == 2'd0) ? '0 : acc_reg) + term;
  assign unused_rsum = ^{rsum[FRAC_W-1:0], rsum[2*W-1:FRAC_W+W+3]};

`ifdef ROT_MATRIX_SAT_EN
  logic [3:0] acc_top;
  logic       clamp;
  logic       sat_reg;

  // Fits in W bits only if the four top accumulator bits are all equal.
  assign acc_top = acc_sum[W+2:W-1];
  assign clamp   = !((&acc_top) || (~|acc_top));
  assign reduced = clamp ? {acc_sum[W+2], {(W-1){~acc_sum[W+2]}}} : acc_sum[W-1:0];
  assign sat_flag = sat_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_reg <= 1'b0;
    end else if (state_reg == S_LOAD) begin
      sat_reg <= 1'b0;
    end else if (in_pass && (k_reg == 2'd2) && clamp) begin
      sat_reg <= 1'b1;
    end
  end
`else
  assign reduced  = acc_sum[W-1:0];
  assign sat_flag = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  state_next = S_PASS1;
      S_PASS1: if (last_mac) state_next = S_PASS2;
      S_PASS2: if (last_mac) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      angle_reg      <= '0;
      cx_reg         <= '0;
      cy_reg         <= '0;
      i_reg          <= '0;
      j_reg          <= '0;
      k_reg          <= '0;
      acc_reg        <= '0;
      selected_value <= '0;
      for (int n = 0; n < 9; n++) begin
        p_reg[n]    <= '0;
        m_reg[n]    <= '0;
        bank_reg[n] <= '0;
      end
    end else begin
      state_reg <= state_next;

      if ((state_reg == S_IDLE) && start) begin
        angle_reg <= angle_idx;
        cx_reg    <= cx;
        cy_reg    <= cy;
      end

      if (state_reg == S_LOAD) begin
        i_reg <= '0;
        j_reg <= '0;
        k_reg <= '0;
      end

      if (in_pass) begin
        acc_reg <= acc_sum;
        // k inner, j middle, i outer; wraps to all-zero after the last MAC
        // so pass 2 starts cleanly.
        if (k_reg == 2'd2) begin
          k_reg <= '0;
          if (state_reg == S_PASS1) p_reg[o_idx] <= reduced;
          else                      m_reg[o_idx] <= reduced;
          if (j_reg == 2'd2) begin
            j_reg <= '0;
            i_reg <= (i_reg == 2'd2) ? 2'd0 : i_reg + 2'd1;
          end else begin
            j_reg <= j_reg + 2'd1;
          end
        end else begin
          k_reg <= k_reg + 2'd1;
        end
      end

      // The bank only changes here, so a read can never mix two runs.
      if (state_reg == S_DONE) begin
        for (int n = 0; n < 9; n++) bank_reg[n] <= m_reg[n];
      end

      selected_value <= (selection < 4'd9) ? bank_reg[selection] : '0;
    end
  end

endmodule

// File: tb/tb_rotation_matrix_engine.sv
// tb_rotation_matrix_engine
//   Directed bench for rotation_matrix_engine. Runs are driven with a timing
//   check (busy/done cycle positions); element reads push their hand-computed
//   expected value into a scoreboard queue and a separate monitor pops and
//   compares whenever a registered read result is presented.
module tb_rotation_matrix_engine;

  localparam int W = 33;
  localparam logic [W-1:0] ONE = 33'h0_0010_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   angle_idx;
  logic [10:0]  cx, cy;
  logic         busy, done;
  logic [3:0]   selection;
  logic [W-1:0] selected_value;
  logic         sat_flag;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [$];
  string        name_q [$];
  logic         rd_req = 1'b0;
  logic         rd_valid = 1'b0;

  rotation_matrix_engine dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .angle_idx      (angle_idx),
    .cx             (cx),
    .cy             (cy),
    .busy           (busy),
    .done           (done),
    .selection      (selection),
    .selected_value (selected_value),
    .sat_flag       (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Read result is registered: valid one edge after the request is sampled.
  always @(posedge clk) rd_valid <= rd_req;

  always @(negedge clk) begin
    logic [W-1:0] e;
    string        nm;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow actual=%h required=none", selected_value);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, {31'd0, selected_value}, {31'd0, e});
        $display("read %s value=%h expected=%h", nm, selected_value, e);
      end
    end
  end

  task automatic read_elem(input int sel, input logic [W-1:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    selection = 4'(sel);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic read_all(input logic [W-1:0] m [9], input string tag);
    for (int e = 0; e < 9; e++) read_elem(e, m[e], $sformatf("%s_M%0d%0d", tag, e / 3, e % 3));
    drain();
  endtask

  // One run. n counts sample points after the start edge (n=1: first busy
  // cycle). Optional extra start pulses, a mid-run bank check and a reset.
  task automatic run(input int a, input int x, input int y,
                     input int p1, input int p2,
                     input int mid_at, input logic [W-1:0] mid_exp,
                     input int rst_at);
    int n, done_at, done_cnt, idle_at;
    angle_idx = 3'(a);
    cx = 11'(x);
    cy = 11'(y);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    done_at = -1;
    done_cnt = 0;
    idle_at = -1;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    while (idle_at < 0 && n < 100) begin
      if (done) begin
        done_cnt++;
        done_at = n;
      end
      if (n == mid_at) check("bank_hold_mid_run", {31'd0, selected_value}, {31'd0, mid_exp});
      if (n == rst_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_selected_value", {31'd0, selected_value}, 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 60; c++) begin
          @(posedge clk);
          #1;
          if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        $display("run angle=%0d cx=%0d cy=%0d aborted by reset at n=%0d", a, x, y, n);
        return;
      end
      start = (n == p1) || (n == p2);
      @(posedge clk);
      #1;
      n++;
      if (!busy) idle_at = n;
    end
    start = 1'b0;
    check("done_cycle", 64'(done_at), 64'd56);
    check("done_count", 64'(done_cnt), 64'd1);
    check("idle_cycle", 64'(idle_at), 64'd57);
    $display("run angle=%0d cx=%0d cy=%0d done_at=%0d idle_at=%0d sat=%0b",
             a, x, y, done_at, idle_at, sat_flag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] m_zero [9];
    logic [W-1:0] m_id   [9];
    logic [W-1:0] m_90   [9];
    logic [W-1:0] exp_m02;
    logic         exp_sat;
    longint       wrap_v;

    m_zero = '{default: '0};
    m_id   = '{ONE, 0, 0, 0, ONE, 0, 0, 0, ONE};
    // 90 deg about (100,100): M02 = cx+cy = 200, M12 = cy-cx = 0.
    m_90   = '{0, 33'h1_FFF0_0000, 33'h0_0C80_0000, ONE, 0, 0, 0, 0, ONE};

    reset = 1'b1;
    start = 1'b0;
    angle_idx = '0;
    cx = '0;
    cy = '0;
    selection = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_sat", {63'd0, sat_flag}, 64'd0);
    check("reset_selected_value", {31'd0, selected_value}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    read_all(m_zero, "reset");

    // Identity.
    run(0, 0, 0, -1, -1, -1, '0, -1);
    read_all(m_id, "ident");
    check("ident_sat", {63'd0, sat_flag}, 64'd0);

    // 90 deg with ignored start pulses; bank must still show identity M00
    // just before the new result lands.
    selection = 4'd0;
    run(6, 100, 100, 10, 30, 55, ONE, -1);
    read_all(m_90, "rot90");
    read_elem(12, '0, "sel12_out_of_range");
    read_elem(15, '0, "sel15_out_of_range");
    drain();

    // 30 deg: cos = round(0.8660254*2^20) = 908093.45 -> 0xDDB3D,
    // sin = 0.5 -> 0x80000.
    run(2, 0, 0, -1, -1, -1, '0, -1);
    read_elem(0, 33'h0_000D_DB3D, "rot30_M00");
    read_elem(1, 33'h1_FFF8_0000, "rot30_M01");
    read_elem(2, '0, "rot30_M02");
    read_elem(3, 33'h0_0008_0000, "rot30_M10");
    read_elem(4, 33'h0_000D_DB3D, "rot30_M11");
    read_elem(5, '0, "rot30_M12");
    drain();

    // 105 deg about (2047,2047). LUT: cos = round(-0.258819*2^20) = -271391,
    // sin = round(0.965926*2^20) = 1012847. M02 = 2047*(-cos) + 2047*sin +
    // 2047*2^20, which exceeds the positive W-bit range.
    wrap_v = 64'd2047 * 64'd271391 + 64'd2047 * 64'd1012847 + 64'd2047 * (64'd1 << 20);
`ifdef ROT_MATRIX_SAT_EN
    exp_m02 = 33'h0_FFFF_FFFF;
    exp_sat = 1'b1;
`else
    exp_m02 = wrap_v[32:0];
    exp_sat = 1'b0;
`endif
    run(7, 2047, 2047, -1, -1, -1, '0, -1);
    read_elem(2, exp_m02, "sat_M02");
    read_elem(8, ONE, "sat_M22");
    drain();
    check("sat_flag_after_overflow", {63'd0, sat_flag}, {63'd0, exp_sat});

    // A clean run afterwards clears the sticky flag.
    run(0, 0, 0, -1, -1, -1, '0, -1);
    check("sat_flag_cleared", {63'd0, sat_flag}, 64'd0);
    read_elem(0, ONE, "post_sat_M00");
    drain();

    // Reset in the middle of a 90 deg run: bank clears, no done; then a
    // fresh run completes normally.
    run(6, 100, 100, -1, -1, -1, '0, 20);
    read_all(m_zero, "abort");
    run(6, 100, 100, -1, -1, -1, '0, -1);
    read_all(m_90, "rerun90");

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
